// File: rtl/aer_event_receiver.sv
// ============================================================================
// aer_event_receiver: AER Req/Ack responder with per-channel saturating
// counters; define AER_TIMEOUT_EN for the Ack timeout / err path. Rev 1.0
// ============================================================================
`default_nettype none

module aer_event_receiver #(
  parameter int NUM_CH      = 2,
  parameter int CH_W        = 1,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_in,
  input  logic [CH_W-1:0]  i_addr_ch,
  input  logic             i_addr_up,
  output logic             o_ack_out,
  output logic             o_ev_valid,
  output logic [CH_W-1:0]  o_ev_ch,
  output logic             o_ev_up,
  input  logic             i_ev_ready,
  input  logic [CH_W-1:0]  i_cnt_sel,
  output logic [CNT_W-1:0] o_cnt_val,
  input  logic             i_cnt_clr,
  output logic             o_err
);

`ifdef AER_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_OFFER, S_ACK, S_RECOVER
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_OFFER, S_ACK
  } state_t;
`endif

  localparam logic signed [CNT_W-1:0] c_cnt_max = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] c_cnt_min = {1'b1, {(CNT_W-1){1'b0}}};

  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    w_req_s;
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_accept;
  logic                    w_capture;
  logic                    r_ack;
  logic [CH_W-1:0]         r_ev_ch;
  logic                    r_ev_up;
  logic signed [CNT_W-1:0] r_cnt [NUM_CH];
  logic [CNT_W-1:0]        w_cnt_val;

`ifdef AER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
  logic            w_to_hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_req_in};
  end
  assign w_req_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
`ifdef AER_TIMEOUT_EN
    w_to_hit    = 1'b0;
`endif
    case (r_state)
      S_IDLE: if (w_req_s) w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        w_capture   = 1'b1;
        // Out-of-range channels are acknowledged without being offered.
        w_state_nxt = (int'(i_addr_ch) < NUM_CH) ? S_OFFER : S_ACK;
      end
      S_OFFER: begin
        if (i_ev_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (!w_req_s) begin
          w_state_nxt = S_IDLE;
        end
`ifdef AER_TIMEOUT_EN
        else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_to_hit    = 1'b1;
          w_state_nxt = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (!w_req_s) w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_ev_ch <= '0;
      r_ev_up <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == S_ACK);
      if (w_capture) begin
        r_ev_ch <= i_addr_ch;
        r_ev_up <= i_addr_up;
      end
    end
  end

  // A clear on the channel being updated in the same cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_cnt_clr && (int'(i_cnt_sel) == c)) begin
          r_cnt[c] <= '0;
        end else if (w_accept && (int'(r_ev_ch) == c)) begin
          if (r_ev_up && (r_cnt[c] != c_cnt_max))       r_cnt[c] <= r_cnt[c] + 1'b1;
          else if (!r_ev_up && (r_cnt[c] != c_cnt_min)) r_cnt[c] <= r_cnt[c] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_cnt_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(i_cnt_sel) == c) w_cnt_val = r_cnt[c];
    end
  end

`ifdef AER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == S_ACK) && w_req_s && !w_to_hit) r_to_cnt <= r_to_cnt + 1'b1;
      else                                            r_to_cnt <= '0;
      if (w_to_hit) r_err <= 1'b1;
    end
  end
  assign o_err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign o_err = 1'b0;
`endif

  assign o_ack_out  = r_ack;
  assign o_ev_valid = (r_state == S_OFFER);
  assign o_ev_ch    = r_ev_ch;
  assign o_ev_up    = r_ev_up;
  assign o_cnt_val  = w_cnt_val;

endmodule

`default_nettype wire
